// File: rtl/fpga_io_conditioner_pkg.sv
// Shared defaults and width helper for the board-I/O conditioner.
package fpga_io_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 4;
  localparam int LED_STRETCH_DEF = 2_500_000;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fpga_io_conditioner_if.sv
// Pad-side and core-side signal bundle of fpga_io_conditioner.
interface fpga_io_conditioner_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) ();

  logic [N_IN-1:0]  i_pad;
  logic [N_IN-1:0]  o_in;
  logic [N_IN-1:0]  o_rise;
  logic [N_IN-1:0]  o_fall;
  logic [N_IN-1:0]  o_led;
  logic [N_OUT-1:0] i_core;
  logic [N_OUT-1:0] o_pad;

  modport slave (
    input  i_pad, i_core,
    output o_in, o_rise, o_fall, o_led, o_pad
  );

  modport master (
    output i_pad, i_core,
    input  o_in, o_rise, o_fall, o_led, o_pad
  );

endinterface

// File: rtl/fpga_io_conditioner_chan.sv
// One input channel: synchroniser, optional glitch filter (FPGA_IO_COND_FILTER_EN),
// edge pulses and stretched activity LED.
module fpga_io_cond_chan
  import fpga_io_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT_LEN    = FILT_LEN_DEF,
  parameter int   LED_STRETCH = LED_STRETCH_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sysclk,
  input  logic rst_ni,
  input  logic pad_i,
  output logic in_o,
  output logic rise_o,
  output logic fall_o,
  output logic led_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_last;
  logic                   lvl;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_ff @(posedge sysclk or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {SYNC_STAGES{RST_VAL}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef FPGA_IO_COND_FILTER_EN
  localparam int            FW       = cnt_w(FILT_LEN - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

  logic          lvl_q, lvl_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Any cycle of agreement drops the count back to zero.
  always_comb begin
    lvl_d  = lvl_q;
    fcnt_d = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_last != lvl_q) begin
      if (fcnt_q == FILT_MAX) begin
        lvl_d  = sync_last;
        rise_d = sync_last;
        fall_d = ~sync_last;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q  <= RST_VAL;
      fcnt_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  localparam int filt_len_unused = FILT_LEN;

  assign lvl = sync_last;

  // The pulse is registered alongside the last stage, so it lines up with in_o.
  always_comb begin
    rise_d = sync_q[SYNC_STAGES-2] & ~sync_last;
    fall_d = ~sync_q[SYNC_STAGES-2] & sync_last;
  end
`endif

  always_ff @(posedge sysclk or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign in_o   = lvl;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  if (LED_STRETCH > 0) begin : g_led_cnt
    localparam int LW = cnt_w(LED_STRETCH);

    logic [LW-1:0] led_cnt_q, led_cnt_d;

    always_comb begin
      led_cnt_d = led_cnt_q;
      if (rise_q | fall_q)          led_cnt_d = LW'(LED_STRETCH);
      else if (led_cnt_q != '0)     led_cnt_d = led_cnt_q - LW'(1);
    end

    always_ff @(posedge sysclk or negedge rst_ni) begin
      if (!rst_ni) led_cnt_q <= '0;
      else         led_cnt_q <= led_cnt_d;
    end

    assign led_o = (led_cnt_q != '0);
  end else begin : g_led_mirror
    logic led_q;

    always_ff @(posedge sysclk or negedge rst_ni) begin
      if (!rst_ni) led_q <= 1'b0;
      else         led_q <= lvl;
    end

    assign led_o = led_q;
  end

endmodule

// File: rtl/fpga_io_conditioner.sv
// Board-I/O conditioner top: N_IN conditioned input channels plus N_OUT IOB output flops.
// Glitch filter is built only when FPGA_IO_COND_FILTER_EN is defined.
module fpga_io_conditioner
  import fpga_io_pkg::*;
#(
  parameter int               N_IN        = 4,
  parameter int               N_OUT       = 2,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int               FILT_LEN    = FILT_LEN_DEF,
  parameter int               LED_STRETCH = LED_STRETCH_DEF,
  parameter logic [N_IN-1:0]  IN_RST_VAL  = '0,
  parameter logic [N_OUT-1:0] OUT_RST_VAL = '0
) (
  input logic                  sysclk,
  input logic                  rst_ni,
  fpga_io_conditioner_if.slave io
);

  for (genvar c = 0; c < N_IN; c++) begin : g_chan
    fpga_io_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .LED_STRETCH (LED_STRETCH),
      .RST_VAL     (IN_RST_VAL[c])
    ) u_chan (
      .sysclk (sysclk),
      .rst_ni (rst_ni),
      .pad_i  (io.i_pad[c]),
      .in_o   (io.o_in[c]),
      .rise_o (io.o_rise[c]),
      .fall_o (io.o_fall[c]),
      .led_o  (io.o_led[c])
    );
  end

  (* IOB = "true" *) logic [N_OUT-1:0] o_pad_q;

  always_ff @(posedge sysclk or negedge rst_ni) begin
    if (!rst_ni) o_pad_q <= OUT_RST_VAL;
    else         o_pad_q <= io.i_core;
  end

  assign io.o_pad = o_pad_q;

endmodule

// File: doc/fpga_io_conditioner.md
# fpga_io_conditioner

Parametrised board-I/O conditioning block for FPGA bring-up of `mpw_top`. It takes N asynchronous pad inputs (SPI, UART RX, switches) and passes each through a configurable synchroniser. An optional glitch filter follows. Each channel produces a level output, rise/fall pulses and a stretched activity-LED drive. The block also registers M core outputs (MISO, UART TX) into IOB flops. It sits between the board pins and `mpw_top`, replacing ad-hoc per-pin IOB registers and LED mirroring.

## Interface
- `N_IN`, 4: number of input channels (≥1).
- `N_OUT`, 2: number of registered output channels (≥1).
- `SYNC_STAGES`, 2: synchroniser depth (≥2).
- `FILT_LEN`, 4: consecutive stable cycles required before the filtered level changes (≥1).
- `LED_STRETCH`, 2_500_000: LED on-time in cycles after an edge; 0 = LED mirrors level.
- `IN_RST_VAL`, all 0: `N_IN`-bit reset value for sync chain, filtered level and `o_in`. UART RX bit is set to 1 for idle-high.
- `OUT_RST_VAL`, all 0: `N_OUT`-bit reset value for `o_pad`.
- `sysclk`, input, 1: single clock; all flops are on its rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `i_pad`, input, N_IN: raw asynchronous pad inputs.
- `o_in`, output, N_IN: conditioned level to core. Reset value: `IN_RST_VAL`.
- `o_rise`, output, N_IN: one-cycle pulse on each 0→1 of `o_in`. Reset value: 0.
- `o_fall`, output, N_IN: one-cycle pulse on each 1→0 of `o_in`. Reset value: 0.
- `o_led`, output, N_IN: activity LED, active high. Reset value: 0.
- `i_core`, input, N_OUT: core-side outputs, synchronous to `sysclk`.
- `o_pad`, output, N_OUT: IOB-registered pad outputs. Reset value: `OUT_RST_VAL`.

## Operation
- **Sync chain:** `SYNC_STAGES` flops per channel; stage 1 samples `i_pad`. All stages reset to `IN_RST_VAL`.
- **Filter:** one counter per channel, `$clog2(FILT_LEN)` bits, holding 0..FILT_LEN-1.
  - When the sync output equals `o_in`: count ← 0.
  - When it differs and count < FILT_LEN-1: count increments.
  - When it differs and count == FILT_LEN-1: `o_in` ← sync output and count ← 0.
  - Any single cycle of agreement restarts the count. Pulses shorter than `FILT_LEN` cycles at the sync output are suppressed entirely.
- **Edges:** registered in the same edge that updates `o_in`.
  - `o_rise` ← new & ~old; `o_fall` ← ~new & old.
  - The pulse is therefore high in exactly the first cycle `o_in` shows the new value. Rise and fall never coincide.
- **LED stretch:** a counter per channel loads `LED_STRETCH` on any edge pulse; otherwise it decrements while nonzero.
  - `o_led` = (counter ≠ 0).
  - A new edge while the counter is nonzero reloads it (retrigger). There is no accumulation.
  - With `LED_STRETCH`=0 there is no counter, and `o_led` is a registered copy of `o_in`, with reset value 0.
- **Output path:** `o_pad` ← `i_core` every cycle. These are IOB flops carrying `(* IOB = "true" *)`.
- **Reset mid-operation:** all counters clear and all outputs return to their reset values asynchronously.
  - No edge pulse is generated by the reset, or by leaving reset, even when `IN_RST_VAL` differs from the pad level.
  - In that case the first edge appears only after normal sync + filter latency.

## Timing
- With the filter, a stable pad change appears on `o_in` after `SYNC_STAGES`+`FILT_LEN` rising edges. With defaults that is 6 cycles.
- Without the filter, the latency is `SYNC_STAGES` edges.
- `o_rise`/`o_fall` have the same latency as `o_in`.
- `o_led` rises 1 cycle after the edge pulse. It then stays high for `LED_STRETCH` cycles after the last edge pulse.
- `i_core`→`o_pad` latency: 1 cycle.
- Deassertion of `rst_ni` is assumed externally synchronised to `sysclk`; the block adds no reset synchroniser.

## Configuration
- Macro: `FPGA_IO_COND_FILTER_EN`.
- When defined, the glitch filter and `FILT_LEN` counters are built.
- When undefined:
  - `o_in` is the last sync stage directly, with no extra flop.
  - Edge pulses are derived from the last two sync stages.
  - `FILT_LEN` is ignored.

## Structure
- Package `fpga_io_pkg` holds:
  - default constants: `SYNC_STAGES_DEF`=2, `FILT_LEN_DEF`=4, `LED_STRETCH_DEF`=2_500_000;
  - the function computing counter width (`cnt_w(n)` = max(1, `$clog2(n+1)`)).
- Sub-module `fpga_io_cond_chan`: one input channel covering sync, filter, edge and LED logic. It is generate-instantiated `N_IN` times.
- The output IOB register stays in the top module.

## Test plan
- **Reset:** `IN_RST_VAL`=4'b0100, `OUT_RST_VAL`=2'b01, `rst_ni`=0. Expect `o_in`=4'b0100, `o_pad`=2'b01, `o_rise`/`o_fall`/`o_led`=0. Release with pads matching reset values: no pulses.
- **Latency:** defaults, `i_pad[0]` 0→1 held. Expect `o_in[0]`=1 and `o_rise[0]`=1 exactly at edge 6, and `o_rise[0]`=0 at edge 7.
- **Glitch:** `i_pad[1]` high for 3 cycles, then low, with `FILT_LEN`=4. Expect no `o_in[1]` change and no pulses. High for 4 cycles: expect exactly one rise then one fall.
- **LED retrigger:** `LED_STRETCH`=10, second edge 5 cycles after the first. Expect `o_led` high continuously and low 10 cycles after the second pulse. With `LED_STRETCH`=0, `o_led` tracks `o_in` delayed by 1 cycle.
- **Mid-operation reset:** assert `rst_ni` while a filter count is at 2 and an LED counter is nonzero. Expect immediate reset values. After release, the counts restart from 0.
- **No-filter build:** with `FPGA_IO_COND_FILTER_EN` undefined, a 1-cycle-stable pad pulse reaches `o_in` after 2 edges. `i_core`=2'b10 gives `o_pad`=2'b10 one cycle later.
